lr35902_dbg_uart_rx: RTL

Serial receive front-end for the LR35902 debug UART.
- Synchronises the asynchronous host `rx` pin and recovers 8N1 bytes using majority-vote oversampling.
- Buffers recovered bytes in a small FIFO and presents them on a valid/ready byte interface to the debug command decoder downstream.
- Drives the `cts` flow-control pin from FIFO occupancy, so the host never overruns the debugger while the CPU is busy stepping.
- All logic is in the `uart_clk` domain.

---
 rtl/lr35902_dbg_pkg.sv | 23 ++
 rtl/lr35902_dbg_fifo.sv | 50 +++++
 rtl/lr35902_dbg_uart_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lr35902_dbg_pkg.sv
// Shared definitions for the LR35902 debug UART: rx state encoding, default bit
// timing and frame bit indices.
package lr35902_dbg_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int DBG_BAUD_DIV = 12;

    // Frame bit indices counted from the start bit.
    localparam logic [3:0] RX_BIT_START    = 4'd0;
    localparam logic [3:0] RX_BIT_D0       = 4'd1;
    localparam logic [3:0] RX_BIT_D7       = 4'd8;
    localparam logic [3:0] RX_BIT_PAR      = 4'd9;
    localparam logic [3:0] RX_BIT_STOP_8N1 = 4'd9;
    localparam logic [3:0] RX_BIT_STOP_8E1 = 4'd10;

endpackage

// File: rtl/lr35902_dbg_fifo.sv
// Synchronous FIFO, registered storage with the head read from the array.
// Latency: a pushed entry is visible one cycle later. Backpressure: push when full is dropped unless a pop happens in the same cycle.
// Pop on empty is ignored; pointers wrap modulo DEPTH (power of two).
module lr35902_dbg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lr35902_dbg_uart_rx.sv
// Debug UART receiver: 2-flop sync, 3-sample majority 8N1 (8E1 with LR35902_DBG_UART_RX_PARITY_EN), byte FIFO, cts.
// Latency: push at T0 + (bits-1)*BAUD_DIV + BAUD_DIV/2 + 1, valid the cycle after.
// Backpressure: valid/ready on output; cts drops when free entries < CTS_LOW_MARK; full FIFO drops bytes with overrun.
module lr35902_dbg_uart_rx
    import lr35902_dbg_pkg::*;
#(
    parameter int BAUD_DIV     = DBG_BAUD_DIV,
    parameter int FIFO_DEPTH   = 4,
    parameter int CTS_LOW_MARK = 2
) (
    input  logic                          uart_clk,
    input  logic                          uart_reset_n,
    input  logic                          rx,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic                          cts,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef LR35902_DBG_UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int SW = $clog2(BAUD_DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SW-1:0] SUB_ONE  = SW'(1);
    localparam logic [SW-1:0] SUB_S0   = SW'(BAUD_DIV / 2 - 1);
    localparam logic [SW-1:0] SUB_S1   = SW'(BAUD_DIV / 2);
    localparam logic [SW-1:0] SUB_DEC  = SW'(BAUD_DIV / 2 + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAUD_DIV - 1);
`ifdef LR35902_DBG_UART_RX_PARITY_EN
    localparam logic [3:0] STOP_BIT = RX_BIT_STOP_8E1;
`else
    localparam logic [3:0] STOP_BIT = RX_BIT_STOP_8N1;
`endif

    rx_state_t     state;
    logic          rx_m;
    logic          rx_s;
    logic [SW-1:0] sub;
    logic [3:0]    bit_idx;
    logic          s0;
    logic          s1;
    logic [7:0]    shreg;
    logic          maj;
    logic          decide;
    logic          pop;
    logic          accept;
    logic          push;
    logic          full;
    logic          empty;
    logic [LW-1:0] lvl_nxt;
`ifdef LR35902_DBG_UART_RX_PARITY_EN
    logic          par_bit;
    logic          par_ok;
`endif

    always_comb begin
        maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        decide  = (state == RX_START || state == RX_DATA || state == RX_STOP) && (sub == SUB_DEC);
        pop     = valid && ready;
        accept  = !full || pop;
`ifdef LR35902_DBG_UART_RX_PARITY_EN
        par_ok  = (par_bit == ^shreg);
        push    = decide && (state == RX_STOP) && maj && par_ok && accept;
`else
        push    = decide && (state == RX_STOP) && maj && accept;
`endif
        lvl_nxt = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_reset_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= RX_IDLE;
            sub       <= '0;
            bit_idx   <= RX_BIT_START;
            s0        <= 1'b1;
            s1        <= 1'b1;
            shreg     <= '0;
            cts       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef LR35902_DBG_UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef LR35902_DBG_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            cts <= (FIFO_DEPTH - int'(lvl_nxt)) >= CTS_LOW_MARK;

            if (sub == SUB_S0) s0 <= rx_s;
            if (sub == SUB_S1) s1 <= rx_s;
            if (sub == SUB_LAST) begin
                sub     <= '0;
                bit_idx <= bit_idx + 4'd1;
            end else begin
                sub <= sub + SUB_ONE;
            end

            case (state)
                RX_IDLE: begin
                    // The start-edge cycle counts as sub-count 0.
                    sub     <= rx_s ? '0 : SUB_ONE;
                    bit_idx <= RX_BIT_START;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (decide) state <= maj ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (decide) begin
                        if (bit_idx <= RX_BIT_D7) shreg <= {maj, shreg[7:1]};
`ifdef LR35902_DBG_UART_RX_PARITY_EN
                        if (bit_idx == RX_BIT_PAR) par_bit <= maj;
`endif
                        if (bit_idx == STOP_BIT - 4'd1) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Decided mid-stop-bit so the next start edge is never missed.
                    if (decide) begin
                        if (!maj) begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end else begin
                            state <= RX_IDLE;
`ifdef LR35902_DBG_UART_RX_PARITY_EN
                            if (!par_ok) parity_err <= 1'b1;
                            else if (!accept) overrun <= 1'b1;
`else
                            if (!accept) overrun <= 1'b1;
`endif
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign valid = !empty;

    lr35902_dbg_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (uart_clk),
        .reset_n   (uart_reset_n),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .data      (data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule
